// File: rtl/ld_st_tag_queue_if.sv
// Handshake and broadcast bundle for the load/store tag queue.
// master drives requests into the queue; slave is the queue itself.
interface ld_st_tag_queue_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_WR = 4,
    parameter int NUM_LU = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready;
    logic [DEPTH-1:0] enq_idx;
    logic             deq_valid;
    logic [WIDTH-1:0] deq_data;
    logic             deq_ready;
    logic             upd_valid [NUM_WR];
    logic [DEPTH-1:0] upd_mask  [NUM_WR];
    logic [WIDTH-1:0] upd_data  [NUM_WR];
    logic             lu_valid  [NUM_LU];
    logic [WIDTH-1:0] lu_key    [NUM_LU];
    logic             lu_hit    [NUM_LU];
    logic [DEPTH-1:0] lu_mask   [NUM_LU];
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport master (
        output flush, enq_valid, enq_data, deq_ready,
               upd_valid, upd_mask, upd_data, lu_valid, lu_key,
        input  enq_ready, enq_idx, deq_valid, deq_data,
               lu_hit, lu_mask, count, full, empty
    );

    modport slave (
        input  flush, enq_valid, enq_data, deq_ready,
               upd_valid, upd_mask, upd_data, lu_valid, lu_key,
        output enq_ready, enq_idx, deq_valid, deq_data,
               lu_hit, lu_mask, count, full, empty
    );
endinterface

// File: rtl/ld_st_tag_queue.sv
// Circular tag queue with broadcast updates to valid slots and a multi-port
// CAM lookup over valid entries. Flush clears occupancy but keeps data.
module ld_st_tag_queue #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_WR = 4,
    parameter int NUM_LU = 8
) (
    input logic             clk,
    input logic             rst,
    ld_st_tag_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic full;
    logic empty;
    logic do_enq;
    logic do_deq;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign q.full      = full;
    assign q.empty     = empty;
    assign q.count     = count_q;
    assign q.enq_ready = !full && !q.flush;
    // Hide the head while rst is high so no retire handshake can complete.
    assign q.deq_valid = !empty && !rst;
    assign q.deq_data  = data_q[head_q];
    assign q.enq_idx   = full ? '0 : (DEPTH'(1) << tail_q);

    assign do_enq = q.enq_valid && q.enq_ready;
    assign do_deq = q.deq_valid && q.deq_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (q.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            // Later ports overwrite earlier ones; a retiring head ignores updates.
            for (int i = 0; i < DEPTH; i++) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (q.upd_valid[p] && q.upd_mask[p][i] && valid_q[i] &&
                        !(do_deq && (PW'(i) == head_q))) begin
                        data_q[i] <= q.upd_data[p];
                    end
                end
            end
            if (do_enq) begin
                data_q[tail_q]  <= q.enq_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            if (do_deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LU; k++) begin : g_lu
        logic [DEPTH-1:0] match;

        always_comb begin
            match = '0;
            for (int i = 0; i < DEPTH; i++) begin
                match[i] = q.lu_valid[k] && valid_q[i] && (data_q[i] == q.lu_key[k]);
            end
        end

        assign q.lu_mask[k] = match;
        assign q.lu_hit[k]  = |match;
    end
endmodule

// File: tb/tb_ld_st_tag_queue.sv
// Directed bench for ld_st_tag_queue: fill/drain, wrap, updates, CAM,
// full-boundary handshakes, flush and reset.
module tb_ld_st_tag_queue;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_WR = 4;
    localparam int NUM_LU = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    ld_st_tag_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .NUM_LU(NUM_LU)) bus ();

    ld_st_tag_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .NUM_LU(NUM_LU)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            bus.upd_valid[p] = 1'b0;
            bus.upd_mask[p]  = '0;
            bus.upd_data[p]  = '0;
        end
        for (int k = 0; k < NUM_LU; k++) begin
            bus.lu_valid[k] = 1'b0;
            bus.lu_key[k]   = '0;
        end
    endtask

    task automatic enq1(input logic [WIDTH-1:0] d);
        bus.enq_valid = 1'b1;
        bus.enq_data  = d;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    task automatic deq_chk(input string tag, input logic [WIDTH-1:0] exp);
        bus.deq_ready = 1'b1;
        #1;
        chk({tag, "_valid"}, 64'(bus.deq_valid), 64'd1);
        chk(tag, 64'(bus.deq_data), 64'(exp));
        tick();
        bus.deq_ready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < NUM_LU; k++) bus.lu_valid[k] = 1'b1;
        #1;
        chk({tag, "_empty"},     64'(bus.empty),     64'd1);
        chk({tag, "_full"},      64'(bus.full),      64'd0);
        chk({tag, "_enq_ready"}, 64'(bus.enq_ready), 64'd1);
        chk({tag, "_deq_valid"}, 64'(bus.deq_valid), 64'd0);
        chk({tag, "_deq_data"},  64'(bus.deq_data),  64'd0);
        chk({tag, "_enq_idx"},   64'(bus.enq_idx),   64'd1);
        chk({tag, "_count"},     64'(bus.count),     64'd0);
        for (int k = 0; k < NUM_LU; k++) begin
            chk({tag, "_lu_hit"},  64'(bus.lu_hit[k]),  64'd0);
            chk({tag, "_lu_mask"}, 64'(bus.lu_mask[k]), 64'd0);
        end
        idle();
    endtask

    initial begin
        int s;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Fill 0..31 then drain in order
        for (int i = 0; i < 32; i++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = WIDTH'(i);
            #1;
            chk("fill_enq_idx", 64'(bus.enq_idx), 64'd1 << i);
            tick();
        end
        bus.enq_valid = 1'b0;
        #1;
        chk("fill_full",      64'(bus.full),      64'd1);
        chk("fill_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("fill_enq_idx0",  64'(bus.enq_idx),   64'd0);
        chk("fill_count",     64'(bus.count),     64'd32);
        for (int i = 0; i < 32; i++) deq_chk("drain_data", WIDTH'(i));
        #1;
        chk("drain_empty", 64'(bus.empty),     64'd1);
        chk("drain_count", 64'(bus.count),     64'd0);
        chk("drain_valid", 64'(bus.deq_valid), 64'd0);

        // Wrap: 20 in, 20 out, then 100..119 leaves tail at slot 8
        for (int i = 0; i < 20; i++) enq1(WIDTH'(50 + i));
        bus.deq_ready = 1'b1;
        repeat (20) tick();
        bus.deq_ready = 1'b0;
        for (int i = 0; i < 20; i++) enq1(WIDTH'(100 + i));
        #1;
        chk("wrap_enq_idx", 64'(bus.enq_idx), 64'd1 << 8);
        chk("wrap_count",   64'(bus.count),   64'd20);
        for (int i = 0; i < 20; i++) deq_chk("wrap_data", WIDTH'(100 + i));

        // Update priority and update to an invalid slot
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) enq1(WIDTH'(16 + i));
        bus.upd_valid[0] = 1'b1; bus.upd_mask[0] = 32'h8;     bus.upd_data[0] = 32'hA;
        bus.upd_valid[3] = 1'b1; bus.upd_mask[3] = 32'h8;     bus.upd_data[3] = 32'hB;
        bus.upd_valid[1] = 1'b1; bus.upd_mask[1] = 32'h400;   bus.upd_data[1] = 32'hC;
        tick();
        idle();
        bus.lu_valid[0] = 1'b1; bus.lu_key[0] = 32'hB;
        bus.lu_valid[1] = 1'b1; bus.lu_key[1] = 32'hA;
        #1;
        chk("upd_win_mask",  64'(bus.lu_mask[0]), 64'h8);
        chk("upd_win_hit",   64'(bus.lu_hit[0]),  64'd1);
        chk("upd_lose_mask", 64'(bus.lu_mask[1]), 64'd0);
        chk("upd_lose_hit",  64'(bus.lu_hit[1]),  64'd0);
        idle();
        deq_chk("upd_deq0", 32'h10);
        deq_chk("upd_deq1", 32'h11);
        deq_chk("upd_deq2", 32'h12);
        deq_chk("upd_deq3", 32'hB);
        for (int i = 0; i < 6; i++) begin
            enq1(WIDTH'(32'h40 + i));
            deq_chk("upd_pass", WIDTH'(32'h40 + i));
        end
        #1;
        chk("upd_invalid_valid", 64'(bus.deq_valid), 64'd0);
        chk("upd_invalid_data",  64'(bus.deq_data),  64'd0);

        // CAM: slots 2 and 5 valid with 7, slot 9 holds 7 but is retired
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) enq1((i == 9) ? WIDTH'(7) : WIDTH'(32'h100 + i));
        bus.deq_ready = 1'b1;
        repeat (10) tick();
        bus.deq_ready = 1'b0;
        for (int j = 0; j < 28; j++) begin
            s = (10 + j) % 32;
            enq1((s == 2 || s == 5) ? WIDTH'(7) : WIDTH'(32'h100 + s));
        end
        bus.lu_valid[3] = 1'b1; bus.lu_key[3] = 32'h7;
        bus.lu_valid[4] = 1'b0; bus.lu_key[4] = 32'h7;
        bus.lu_valid[0] = 1'b1; bus.lu_key[0] = 32'h10C;
        #1;
        chk("cam_mask",     64'(bus.lu_mask[3]), 64'h24);
        chk("cam_hit",      64'(bus.lu_hit[3]),  64'd1);
        chk("cam_off_mask", 64'(bus.lu_mask[4]), 64'd0);
        chk("cam_off_hit",  64'(bus.lu_hit[4]),  64'd0);
        chk("cam_single",   64'(bus.lu_mask[0]), 64'd1 << 12);
        idle();

        // Full queue with enq and deq together: only the dequeue happens
        for (int i = 6; i < 10; i++) enq1(WIDTH'(32'h100 + i));
        #1;
        chk("bnd_full",  64'(bus.full),  64'd1);
        chk("bnd_count", 64'(bus.count), 64'd32);
        bus.enq_valid = 1'b1;
        bus.enq_data  = 32'h55;
        bus.deq_ready = 1'b1;
        #1;
        chk("bnd_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("bnd_deq_data",  64'(bus.deq_data),  64'h10A);
        tick();
        chk("bnd_count31", 64'(bus.count), 64'd31);
        chk("bnd_notfull", 64'(bus.full),  64'd0);
        bus.deq_ready = 1'b0;
        tick();
        bus.enq_valid = 1'b0;
        chk("bnd_count32", 64'(bus.count),    64'd32);
        chk("bnd_refull",  64'(bus.full),     64'd1);
        chk("bnd_head",    64'(bus.deq_data), 64'h10B);

        // Flush overrides enq, deq and upd; data survives
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 32'h77;
        bus.deq_ready = 1'b1;
        bus.upd_valid[2] = 1'b1;
        bus.upd_mask[2]  = '1;
        bus.upd_data[2]  = 32'h99;
        #1;
        chk("flush_enq_ready", 64'(bus.enq_ready), 64'd0);
        tick();
        idle();
        for (int k = 0; k < NUM_LU; k++) begin
            bus.lu_valid[k] = 1'b1;
            bus.lu_key[k]   = (k % 3 == 0) ? WIDTH'(32'h77) : ((k % 3 == 1) ? WIDTH'(32'h99) : WIDTH'(7));
        end
        #1;
        chk("flush_count",    64'(bus.count),    64'd0);
        chk("flush_empty",    64'(bus.empty),    64'd1);
        chk("flush_enq_idx",  64'(bus.enq_idx),  64'd1);
        chk("flush_data_kept", 64'(bus.deq_data), 64'h100);
        for (int k = 0; k < NUM_LU; k++) chk("flush_lu_hit", 64'(bus.lu_hit[k]), 64'd0);
        idle();

        // Reset wins over flush and blocks any retire in that cycle
        enq1(32'h31);
        enq1(32'h32);
        rst           = 1'b1;
        bus.flush     = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 32'h33;
        bus.deq_ready = 1'b1;
        #1;
        chk("rst_no_deq", 64'(bus.deq_valid), 64'd0);
        tick();
        rst = 1'b0;
        idle();
        chk_reset_state("rst_flush");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ld_st_tag_queue.md
LD_ST_TAG_QUEUE -- requirements
Module: ld_st_tag_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: entry data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; power of two, 4..64.
REQ-003 SHALL have parameter NUM_WR, default 4: number of broadcast update ports.
REQ-004 SHALL have parameter NUM_LU, default 8: number of CAM lookup ports.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1: clears the queue.
REQ-008 SHALL have ports enq_valid (input, 1), enq_data (input, WIDTH) and enq_ready (output, 1): allocate at tail.
REQ-009 SHALL have ports enq_idx, output, DEPTH: one-hot mask of the current tail slot.
REQ-010 SHALL have ports deq_valid (output, 1), deq_data (output, WIDTH) and deq_ready (input, 1): retire at head.
REQ-011 SHALL have ports upd_valid[NUM_WR] (input, 1 each), upd_mask[NUM_WR] (input, DEPTH each) and upd_data[NUM_WR] (input, WIDTH each): one-hot or multi-hot broadcast writes.
REQ-012 SHALL have ports lu_valid[NUM_LU] (input, 1 each) and lu_key[NUM_LU] (input, WIDTH each): lookup requests.
REQ-013 SHALL have ports lu_hit[NUM_LU] (output, 1 each) and lu_mask[NUM_LU] (output, DEPTH each): lookup results.
REQ-014 SHALL have ports count (output, log2(DEPTH)+1), full (output, 1) and empty (output, 1).

Function
REQ-015 SHALL hold data[DEPTH], valid[DEPTH], head pointer, tail pointer and count; pointers wrap modulo DEPTH.
REQ-016 SHALL compute full = (count == DEPTH), empty = (count == 0), enq_ready = !full && !flush.
REQ-017 SHALL, on enq_valid && enq_ready, write enq_data to data[tail], set valid[tail], and advance tail by 1 with wrap DEPTH-1 -> 0.
REQ-018 SHALL drive deq_valid = !empty and deq_data = data[head] combinationally, with zero-cycle visibility of head.
REQ-019 SHALL, on deq_valid && deq_ready, clear valid[head] and advance head by 1 with wrap.
REQ-020 SHALL apply simultaneous enqueue and dequeue in one cycle with count unchanged; when full, enqueue is refused in that cycle (no bypass).
REQ-021 SHALL not dequeue an entry in the same cycle it is enqueued into an empty queue; that entry is visible on deq_* the next cycle.
REQ-022 SHALL, for each port p with upd_valid[p], write upd_data[p] to every slot i where upd_mask[p][i] && valid[i]; masks on invalid slots are ignored.
REQ-023 SHALL resolve multiple update ports targeting one slot with the highest-numbered port winning; an update also wins over enqueue data only if the slot was already valid (not possible by REQ-022).
REQ-024 SHALL drop an update to the head slot when that slot is dequeued in the same cycle.
REQ-025 SHALL compute lu_mask[k][i] = lu_valid[k] && valid[i] && (data[i] == lu_key[k]) combinationally from current (pre-edge) state; lu_hit[k] = |lu_mask[k]; both are 0 when lu_valid[k] = 0.
REQ-026 SHALL drive enq_idx = one-hot(tail), and enq_idx = 0 when full.
REQ-027 SHALL give flush priority over enq, deq and upd: next state head = tail = count = 0 and all valid cleared; data contents are left unchanged.
REQ-028 SHALL keep the count arithmetic exact at log2(DEPTH)+1 bits, with no overflow or underflow reachable through legal handshakes.

Reset
REQ-029 SHALL, on rst at a clock edge, set head = tail = 0, count = 0, all valid = 0, all data = 0, overriding every other input including flush.
REQ-030 SHALL drive outputs after reset as follows: empty = 1, full = 0, enq_ready = 1, deq_valid = 0, deq_data = 0, enq_idx = 1 (slot 0), all lu_hit = 0, all lu_mask = 0.
REQ-031 SHALL let rst asserted mid-operation discard all in-flight entries, with no deq handshake completing in that cycle.

Verification
REQ-032 SHALL cover fill/drain: 32 enqueues of data 0..31 -> full = 1 and enq_ready = 0 after the 32nd; then 32 dequeues return 0..31 in order, empty = 1, count = 0.
REQ-033 SHALL cover wrap-around: enqueue 20, dequeue 20, enqueue 20 (values 100..119) -> tail wraps to 8 and dequeue order is 100..119.
REQ-034 SHALL cover update priority: slot 3 valid, port0 mask 0x8 data 0xA, port3 mask 0x8 data 0xB same cycle -> data[3] = 0xB; port1 mask hitting invalid slot 10 -> no change.
REQ-035 SHALL cover CAM lookup: slots 2 and 5 hold 0x7 and are valid, slot 9 holds 0x7 but is invalid -> lu_key 0x7 gives lu_mask = 0x24, lu_hit = 1; lu_valid = 0 gives 0.
REQ-036 SHALL cover a boundary event: full queue with enq and deq asserted together -> only the dequeue occurs, count = 31; next cycle the enqueue is accepted, count = 32.
REQ-037 SHALL cover flush/reset: flush with enq, deq and upd all asserted -> count = 0, no enqueue recorded, all lu_hit = 0 next cycle; rst asserted with flush -> the REQ-030 values.
